// File: rtl/i2c_target_regfile.sv
// I2C target with a small byte register file behind an auto-incrementing pointer.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_target_regfile #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
    parameter int unsigned PTR_W      = 3
) (
    input  logic             clk,
    input  logic             PRESETn,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [7:0]       wr_data,
    output logic             busy,
    input  logic [PTR_W-1:0] dbg_addr,
    output logic [7:0]       dbg_data
);

    localparam int unsigned Depth = 2 ** PTR_W;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRack,
        StIgnore
    } state_e;

    logic [1:0]       scl_sync, sda_sync;
    logic             scl_prev, sda_prev;
    logic             scl, sda, scl_rise, scl_fall, start_det, stop_det, byte_done;
    logic [7:0]       rx_byte, rd_byte;
    logic [PTR_W-1:0] ptr_inc;

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rf_we;
    logic [7:0]       regs_q [Depth];

    // Synchronizers reset to the idle-bus level so release from reset sees no edge.
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);
    assign rx_byte   = {shift_q[6:0], sda};
    assign rd_byte   = regs_q[ptr_q];
    assign ptr_inc   = ptr_q + PTR_W'(1);

    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            wr_data_q  <= '0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_data_q  <= wr_data_d;
            if (rf_we) regs_q[ptr_q] <= rx_byte;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        wr_data_d  = wr_data_q;
        rf_we      = 1'b0;

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            if (scl_rise && (state_q inside {StAddr, StPtr, StWdata})) begin
                shift_d   = rx_byte;
                bit_cnt_d = byte_done ? 4'd0 : bit_cnt_q + 4'd1;
            end
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (byte_done) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            state_d = StAddrAck;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                        end
                    end
                end
                StPtr: begin
                    if (byte_done) begin
                        ptr_d   = rx_byte[PTR_W-1:0];
                        state_d = StPtrAck;
                    end
                end
                StWdata: begin
                    if (byte_done) begin
                        rf_we      = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_ptr_d   = ptr_q;
                        wr_data_d  = rx_byte;
                        ptr_d      = ptr_inc;
                        state_d    = StWdataAck;
                    end
                end
                // First fall after the byte pulls SDA low, the second ends the ACK slot.
                StAddrAck, StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == StAddrAck && rw_q) begin
                                state_d   = StRdata;
                                shift_d   = {rd_byte[6:0], 1'b0};
                                oe_d      = ~rd_byte[7];
                                bit_cnt_d = 4'd1;
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = StRack;
                        end else begin
                            oe_d      = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                // Next byte is latched here; its MSB goes out on the following fall.
                StRack: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            ptr_d     = ptr_inc;
                            shift_d   = regs_q[ptr_inc];
                            bit_cnt_d = '0;
                            state_d   = StRdata;
                        end else begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                        end
                    end
                end
                StIgnore: oe_d = 1'b0;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sda_oe   = oe_q;
        busy     = busy_q;
        wr_valid = wr_valid_q;
        wr_ptr   = wr_ptr_q;
        wr_data  = wr_data_q;
        dbg_data = regs_q[dbg_addr];
    end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Synthesizable I2C target (slave) answering the APB-to-I2C bridge on the shared SDA/SCL bus.
- Replaces the behavioural slave model in system-level sims, and serves as the far-end responder in silicon test chips.
- Decodes START/STOP, matches a 7-bit address, writes and reads an internal byte register file with an auto-incrementing pointer, and drives SDA open-drain.

Parameters:
- SLAVE_ADDR, 7'h3C: 7-bit target address.
- PTR_W, 3: register pointer width; the register file holds 2**PTR_W bytes.

Ports:
- clk  in  1: system clock; at least 16x the SCL frequency.
- PRESETn  in  1: asynchronous active-low reset.
- scl_i  in  1: SCL pin input; asynchronous to clk.
- sda_i  in  1: SDA pin input; asynchronous to clk.
- sda_oe  out  1: 1 pulls SDA low; 0 releases it. The target never drives SCL.
- wr_valid  out  1: one-cycle pulse for each data byte written by the master.
- wr_ptr  out  PTR_W: register index of the byte just written.
- wr_data  out  8: value of the byte just written.
- busy  out  1: high from an address-matched START until STOP or NACK/idle.
- dbg_addr  in  PTR_W: backdoor register read index, for bench and debug.
- dbg_data  out  8: regfile[dbg_addr]; combinational.

Behaviour:
- Reset: asynchronous on PRESETn low. This is the only clock and reset; both are fixed as stated above.
- Reset values: sda_oe=0, wr_valid=0, wr_ptr=0, wr_data=0, busy=0, all regfile bytes 8'h00, pointer 0, state IDLE. Reset asserted mid-transfer releases SDA immediately.
- Input conditioning: scl_i and sda_i pass through 2-flop synchronizers, then a 1-cycle history register for edge detection. Latency from pin to internal event is 3 clk.
- Bus events (SCL high = synchronized SCL high):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - These take priority over all state logic.
  - START in any state → ADDR, bit count 0, sda_oe=0.
  - STOP in any state → IDLE, sda_oe=0, busy=0.
- Data timing: SDA is sampled on SCL rising edges, MSB first. sda_oe changes only on SCL falling edges (or on START/STOP/reset).
- States and transitions:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits. On the 8th rise, compare bits[7:1] with SLAVE_ADDR.
    - Mismatch → IGNORE.
    - Match → ADDR_ACK; set busy=1; latch R/W.
  - ADDR_ACK: next SCL fall sets sda_oe=1; the following fall releases it.
    - If R/W=0 → PTR.
    - If R/W=1 → RDATA, driving bit 7 of regfile[ptr] on that same fall.
  - PTR: shifts in 8 bits. ptr = low PTR_W bits; upper bits are ignored. Goes to PTR_ACK, which ACKs as above, then → WDATA.
  - WDATA: shifts in 8 bits. On the 8th rise:
    - regfile[ptr] = byte; pulse wr_valid for 1 clk with wr_ptr=ptr and wr_data=byte.
    - ptr increments modulo 2**PTR_W (wrap 7→0).
    - → WDATA_ACK, which ACKs, then → WDATA.
  - RDATA: on each SCL fall, sda_oe = ~current bit. After the 8th bit's fall, sda_oe=0 → RACK.
  - RACK: on the SCL rise, sample the master's bit.
    - 0 (ACK): ptr++ (wrap), → RDATA, driving the new byte's MSB on the next fall.
    - 1 (NACK): → IGNORE, busy=0.
  - IGNORE: sda_oe=0; waits for START or STOP.
- Read-byte latch: the read byte is latched into the shift register when entering RDATA. A concurrent write to the same index via a new transaction cannot occur while a read is in progress.
- Repeated START after PTR/WDATA: ptr is retained, so a write-pointer-then-read sequence works.
- A START during an ACK slot releases SDA in the same cycle it is detected.

Test Plan:
- Write: START, 0x78, 0x02, 0xA5, 0x5A, STOP → ACK on all 4 bytes. wr_valid pulses twice with (2,A5) then (3,5A). dbg_data@2=A5, @3=5A.
- Random read: START, 0x78, 0x02, Sr, 0x79, master ACK then NACK → SDA bytes A5, 5A. sda_oe=0 after NACK; busy falls.
- Address miss: START, 0x40 → no ACK (SDA high at the 9th clock). No wr_valid. busy stays 0 through STOP.
- Wrap: pointer 0x07, write 0x11, 0x22 → regfile[7]=11, regfile[0]=22. Read from 7 for 2 bytes returns 11, 22.
- Pointer upper bits: pointer byte 0xF9 → ptr=1. Write 0x33 → dbg_data@1=33.
- Reset mid-read: assert PRESETn low while sda_oe=1 → sda_oe=0 asynchronously; regfile cleared to 00. The next transaction from START succeeds.
